// File: rtl/pixel_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pixel_slot_arbiter
// Purpose  : Time-division arbiter for the single-port frame-buffer RAM.
//            One pixel period is DIV clk cycles and each cycle is one RAM
//            slot. Phase 0 belongs to the video read and phase 1 to the
//            camera write buffer. Any slot not taken by its owner goes to
//            the auxiliary (game-logic) requester.
//            Also owns the phase counter and emits the pixel tick.
// Ports    : clk, reset (async, active-high)
//            pix_tick, phase                     - pixel-period timing
//            vid_req/addr -> vid_rdata/valid     - video read port
//            cam_wr_valid/addr/wdata, ready      - camera write port
//            aux_req/we/addr/wdata -> aux_gnt,
//              aux_rdata/rvalid                  - auxiliary access port
//            mem_en/we/addr/wdata, mem_rdata     - RAM port (1-cycle read)
//            aux_grant_cnt                       - aux grant counter
// Options  : PIXEL_ARB_PERF_EN - when defined, aux_grant_cnt counts aux
//            grants and saturates at 16'hFFFF. When undefined, it is tied
//            to 0.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_slot_arbiter #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 16,
    parameter int DIV    = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic              pix_tick,
    output logic [3:0]        phase,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_valid,
    input  logic              cam_wr_valid,
    input  logic [ADDR_W-1:0] cam_addr,
    input  logic [DATA_W-1:0] cam_wdata,
    output logic              cam_wr_ready,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_gnt,
    output logic [DATA_W-1:0] aux_rdata,
    output logic              aux_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       aux_grant_cnt
);

    localparam logic [3:0] c_last_phase = 4'(DIV - 1);

    logic [3:0]        phase_q, phase_d;
    logic              pix_tick_q, pix_tick_d;
    logic              buf_full_q, buf_full_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [DATA_W-1:0] buf_data_q, buf_data_d;
    logic              vid_valid_q, vid_valid_d;
    logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;
    logic              aux_rvalid_q, aux_rvalid_d;
    logic [DATA_W-1:0] aux_rdata_q, aux_rdata_d;
    logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
    logic [DATA_W-1:0] wdata_hold_q, wdata_hold_d;

    logic vid_issue, cam_issue, aux_issue, cam_hs;

    always_comb begin
        vid_issue = (phase_q == 4'd0) && vid_req;
        cam_issue = (phase_q == 4'd1) && buf_full_q;
        aux_issue = aux_req && !vid_issue && !cam_issue;
        // Ready is low while full, so a handshake never coincides with a drain.
        cam_hs    = cam_wr_valid && !buf_full_q;

        mem_en    = 1'b0;
        mem_we    = 1'b0;
        // Idle slots keep presenting the last address/data to the RAM.
        mem_addr  = addr_hold_q;
        mem_wdata = wdata_hold_q;
        if (vid_issue) begin
            mem_en   = 1'b1;
            mem_addr = vid_addr;
        end else if (cam_issue) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = buf_addr_q;
            mem_wdata = buf_data_q;
        end else if (aux_issue) begin
            mem_en   = 1'b1;
            mem_we   = aux_we;
            mem_addr = aux_addr;
            if (aux_we) begin
                mem_wdata = aux_wdata;
            end
        end
        addr_hold_d  = mem_addr;
        wdata_hold_d = mem_wdata;

        phase_d    = (phase_q == c_last_phase) ? 4'd0 : phase_q + 4'd1;
        // Registered so the tick is high in the cycle where phase wraps to 0.
        pix_tick_d = (phase_q == c_last_phase);

        buf_full_d = buf_full_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        if (cam_issue) begin
            buf_full_d = 1'b0;
        end
        if (cam_hs) begin
            buf_full_d = 1'b1;
            buf_addr_d = cam_addr;
            buf_data_d = cam_wdata;
        end

        vid_valid_d  = vid_issue;
        aux_rvalid_d = aux_issue && !aux_we;
        vid_rdata_d  = vid_valid_q  ? mem_rdata : vid_rdata_q;
        aux_rdata_d  = aux_rvalid_q ? mem_rdata : aux_rdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q      <= 4'd0;
            pix_tick_q   <= 1'b0;
            buf_full_q   <= 1'b0;
            buf_addr_q   <= '0;
            buf_data_q   <= '0;
            vid_valid_q  <= 1'b0;
            vid_rdata_q  <= '0;
            aux_rvalid_q <= 1'b0;
            aux_rdata_q  <= '0;
            addr_hold_q  <= '0;
            wdata_hold_q <= '0;
        end else begin
            phase_q      <= phase_d;
            pix_tick_q   <= pix_tick_d;
            buf_full_q   <= buf_full_d;
            buf_addr_q   <= buf_addr_d;
            buf_data_q   <= buf_data_d;
            vid_valid_q  <= vid_valid_d;
            vid_rdata_q  <= vid_rdata_d;
            aux_rvalid_q <= aux_rvalid_d;
            aux_rdata_q  <= aux_rdata_d;
            addr_hold_q  <= addr_hold_d;
            wdata_hold_q <= wdata_hold_d;
        end
    end

    assign phase        = phase_q;
    assign pix_tick     = pix_tick_q;
    assign cam_wr_ready = ~buf_full_q;
    assign aux_gnt      = aux_issue;
    assign vid_valid    = vid_valid_q;
    assign aux_rvalid   = aux_rvalid_q;
    // Read data arrives one cycle after issue, which is the valid cycle.
    // So present it straight through while valid, then hold the captured copy.
    assign vid_rdata    = vid_valid_q  ? mem_rdata : vid_rdata_q;
    assign aux_rdata    = aux_rvalid_q ? mem_rdata : aux_rdata_q;

`ifdef PIXEL_ARB_PERF_EN
    logic [15:0] aux_cnt_q, aux_cnt_d;

    always_comb begin
        aux_cnt_d = aux_cnt_q;
        if (aux_issue && (aux_cnt_q != 16'hFFFF)) begin
            aux_cnt_d = aux_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aux_cnt_q <= 16'd0;
        end else begin
            aux_cnt_q <= aux_cnt_d;
        end
    end

    assign aux_grant_cnt = aux_cnt_q;
`else
    assign aux_grant_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pixel_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_slot_arbiter
// Purpose  : Directed self-checking bench for pixel_slot_arbiter with DIV=4.
//            Cycle numbering: cycle 0 is the first cycle after reset release.
//            The RAM model returns addr[15:0] one cycle after a read.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_slot_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_tick;
    logic [3:0]  phase;
    logic        vid_req;
    logic [16:0] vid_addr;
    logic [15:0] vid_rdata;
    logic        vid_valid;
    logic        cam_wr_valid;
    logic [16:0] cam_addr;
    logic [15:0] cam_wdata;
    logic        cam_wr_ready;
    logic        aux_req;
    logic        aux_we;
    logic [16:0] aux_addr;
    logic [15:0] aux_wdata;
    logic        aux_gnt;
    logic [15:0] aux_rdata;
    logic        aux_rvalid;
    logic        mem_en;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0;
    logic [15:0] aux_grant_cnt;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;

    pixel_slot_arbiter #(.ADDR_W(17), .DATA_W(16), .DIV(4)) dut (
        .clk(clk), .reset(reset), .pix_tick(pix_tick), .phase(phase),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata),
        .vid_valid(vid_valid), .cam_wr_valid(cam_wr_valid), .cam_addr(cam_addr),
        .cam_wdata(cam_wdata), .cam_wr_ready(cam_wr_ready), .aux_req(aux_req),
        .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_gnt(aux_gnt), .aux_rdata(aux_rdata), .aux_rvalid(aux_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .aux_grant_cnt(aux_grant_cnt)
    );

    always #5 clk = ~clk;

    // RAM model: read data equals the low address bits, one cycle later.
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= mem_addr[15:0];
    end

    task automatic idle_inputs();
        vid_req = 0; vid_addr = '0; cam_wr_valid = 0; cam_addr = '0; cam_wdata = '0;
        aux_req = 0; aux_we = 0; aux_addr = '0; aux_wdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1; cyc++;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        @(posedge clk); @(posedge clk); #1;
        reset = 0;
        cyc = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        @(posedge clk); @(posedge clk); #1;
        chk_cnt++;
        if ({phase, pix_tick, vid_valid, aux_rvalid, cam_wr_valid ? 1'b0 : cam_wr_ready, mem_en} !== 9'b0000_0_0_0_1_0)
            $display("FAIL reset_ctrl: got phase=%0d tick=%b vv=%b arv=%b rdy=%b en=%b required 0,0,0,0,1,0",
                     phase, pix_tick, vid_valid, aux_rvalid, cam_wr_ready, mem_en);
        else pass_cnt++;
        chk_cnt++;
        if ({vid_rdata, aux_rdata, aux_grant_cnt} !== 48'h0)
            $display("FAIL reset_data: got vid_rdata=%h aux_rdata=%h cnt=%h required 0",
                     vid_rdata, aux_rdata, aux_grant_cnt);
        else pass_cnt++;
    endtask

    task automatic test_phase_tick();
        logic [3:0] exp_ph;
        logic       exp_tick;
        do_reset();
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) next_cycle();
            settle();
            exp_ph   = 4'(cyc % 4);
            exp_tick = (cyc > 0) && (cyc % 4 == 0);
            chk_cnt++;
            if (phase !== exp_ph || pix_tick !== exp_tick || mem_en !== 1'b0)
                $display("FAIL phase_tick cyc=%0d: got phase=%0d tick=%b en=%b required %0d,%b,0",
                         cyc, phase, pix_tick, mem_en, exp_ph, exp_tick);
            else pass_cnt++;
        end
    endtask

    task automatic test_video();
        logic exp_en, exp_vv;
        do_reset();
        for (int k = 0; k <= 11; k++) begin
            if (k > 0) next_cycle();
            vid_req = 1; vid_addr = 17'h00100;
            settle();
            exp_en = (cyc % 4 == 0);
            exp_vv = (cyc % 4 == 1);
            chk_cnt++;
            if (mem_en !== exp_en || mem_we !== 1'b0 || (exp_en && mem_addr !== 17'h00100))
                $display("FAIL vid_issue cyc=%0d: got en=%b we=%b addr=%h required en=%b we=0 addr=00100",
                         cyc, mem_en, mem_we, mem_addr, exp_en);
            else pass_cnt++;
            chk_cnt++;
            if (vid_valid !== exp_vv || (exp_vv && vid_rdata !== 16'h0100))
                $display("FAIL vid_return cyc=%0d: got valid=%b data=%h required valid=%b data=0100",
                         cyc, vid_valid, vid_rdata, exp_vv);
            else pass_cnt++;
        end
        idle_inputs();
    endtask

    task automatic test_camera();
        do_reset();
        next_cycle(); next_cycle();           // cycle 2, phase 2
        cam_wr_valid = 1; cam_addr = 17'h00010; cam_wdata = 16'h1234;
        settle();
        chk_cnt++;
        if (cam_wr_ready !== 1'b1) $display("FAIL cam_ready_p2: got %b required 1", cam_wr_ready);
        else pass_cnt++;
        next_cycle();                         // cycle 3
        cam_wr_valid = 0; cam_addr = 17'h1FFFF; cam_wdata = 16'hFFFF;
        settle();
        chk_cnt++;
        if (cam_wr_ready !== 1'b0) $display("FAIL cam_ready_full: got %b required 0", cam_wr_ready);
        else pass_cnt++;
        next_cycle();                         // cycle 4, phase 0: no write yet
        settle();
        chk_cnt++;
        if (mem_en !== 1'b0 || cam_wr_ready !== 1'b0)
            $display("FAIL cam_wait_p0: got en=%b rdy=%b required 0,0", mem_en, cam_wr_ready);
        else pass_cnt++;
        next_cycle();                         // cycle 5, phase 1: drain
        settle();
        chk_cnt++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 17'h00010 || mem_wdata !== 16'h1234)
            $display("FAIL cam_write: got en=%b we=%b addr=%h data=%h required 1,1,00010,1234",
                     mem_en, mem_we, mem_addr, mem_wdata);
        else pass_cnt++;
        next_cycle();                         // cycle 6: ready back, bus holds
        settle();
        chk_cnt++;
        if (cam_wr_ready !== 1'b1 || mem_en !== 1'b0 || mem_addr !== 17'h00010 || mem_wdata !== 16'h1234)
            $display("FAIL cam_after: got rdy=%b en=%b addr=%h data=%h required 1,0,00010,1234",
                     cam_wr_ready, mem_en, mem_addr, mem_wdata);
        else pass_cnt++;
    endtask

    task automatic test_aux();
        do_reset();
        next_cycle();                         // cycle 1, phase 1, buffer empty
        aux_req = 1; aux_we = 0; aux_addr = 17'h00020;
        settle();
        chk_cnt++;
        if (aux_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 17'h00020)
            $display("FAIL aux_read_gnt: got gnt=%b en=%b we=%b addr=%h required 1,1,0,00020",
                     aux_gnt, mem_en, mem_we, mem_addr);
        else pass_cnt++;
        next_cycle();                         // cycle 2
        aux_req = 0;
        settle();
        chk_cnt++;
        if (aux_rvalid !== 1'b1 || aux_rdata !== 16'h0020 || aux_gnt !== 1'b0)
            $display("FAIL aux_read_ret: got rv=%b data=%h gnt=%b required 1,0020,0",
                     aux_rvalid, aux_rdata, aux_gnt);
        else pass_cnt++;
        next_cycle();                         // cycle 3, phase 3: aux write
        aux_req = 1; aux_we = 1; aux_addr = 17'h00030; aux_wdata = 16'hBEEF;
        settle();
        chk_cnt++;
        if (aux_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 17'h00030 || mem_wdata !== 16'hBEEF || aux_rdata !== 16'h0020)
            $display("FAIL aux_write: got gnt=%b we=%b addr=%h data=%h held=%h required 1,1,00030,BEEF,0020",
                     aux_gnt, mem_we, mem_addr, mem_wdata, aux_rdata);
        else pass_cnt++;
        next_cycle();                         // cycle 4
        aux_req = 0; aux_we = 0;
        settle();
        chk_cnt++;
        if (aux_rvalid !== 1'b0) $display("FAIL aux_write_norv: got %b required 0", aux_rvalid);
        else pass_cnt++;
    endtask

    task automatic test_contention();
        logic exp_gnt;
        int   exp_grants = 0;
        do_reset();
        for (int k = 0; k <= 13; k++) begin
            if (k > 0) next_cycle();
            vid_req = 1; vid_addr = 17'h00100;
            cam_wr_valid = (k >= 2); cam_addr = 17'h00040; cam_wdata = 16'h5555;
            aux_req = (k >= 5 && k <= 12); aux_we = 0; aux_addr = 17'h00020;
            settle();
            if (k >= 5 && k <= 12) begin
                exp_gnt = (k % 4 >= 2);
                if (exp_gnt) exp_grants++;
                chk_cnt++;
                if (aux_gnt !== exp_gnt)
                    $display("FAIL contend_gnt cyc=%0d: got %b required %b", k, aux_gnt, exp_gnt);
                else pass_cnt++;
                if (k % 4 == 0) begin
                    chk_cnt++;
                    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 17'h00100)
                        $display("FAIL contend_vid cyc=%0d: got en=%b we=%b addr=%h required 1,0,00100",
                                 k, mem_en, mem_we, mem_addr);
                    else pass_cnt++;
                end
                if (k % 4 == 1) begin
                    chk_cnt++;
                    if (mem_we !== 1'b1 || mem_addr !== 17'h00040 || mem_wdata !== 16'h5555 || vid_valid !== 1'b1 || vid_rdata !== 16'h0100)
                        $display("FAIL contend_cam cyc=%0d: got we=%b addr=%h data=%h vv=%b vd=%h required 1,00040,5555,1,0100",
                                 k, mem_we, mem_addr, mem_wdata, vid_valid, vid_rdata);
                    else pass_cnt++;
                end
                if (k % 4 == 3) begin
                    chk_cnt++;
                    if (aux_rvalid !== 1'b1 || aux_rdata !== 16'h0020)
                        $display("FAIL contend_aux_ret cyc=%0d: got rv=%b data=%h required 1,0020",
                                 k, aux_rvalid, aux_rdata);
                    else pass_cnt++;
                end
            end
        end
`ifndef PIXEL_ARB_PERF_EN
        exp_grants = 0;
`endif
        chk_cnt++;
        if (aux_grant_cnt !== 16'(exp_grants))
            $display("FAIL grant_cnt: got %0d required %0d", aux_grant_cnt, exp_grants);
        else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        next_cycle();                         // cycle 1: load buffer
        cam_wr_valid = 1; cam_addr = 17'h00050; cam_wdata = 16'hAAAA;
        settle();
        next_cycle();                         // cycle 2: full, aux read in flight
        cam_wr_valid = 0;
        aux_req = 1; aux_we = 0; aux_addr = 17'h00060;
        settle();
        chk_cnt++;
        if (cam_wr_ready !== 1'b0 || aux_gnt !== 1'b1)
            $display("FAIL mid_setup: got rdy=%b gnt=%b required 0,1", cam_wr_ready, aux_gnt);
        else pass_cnt++;
        reset = 1;
        #1;
        chk_cnt++;
        if (phase !== 4'd0 || cam_wr_ready !== 1'b1 || aux_rvalid !== 1'b0)
            $display("FAIL mid_async: got phase=%0d rdy=%b rv=%b required 0,1,0", phase, cam_wr_ready, aux_rvalid);
        else pass_cnt++;
        aux_req = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 0;
        cyc = 0;
        for (int k = 0; k <= 7; k++) begin
            if (k > 0) next_cycle();
            settle();
            chk_cnt++;
            if (mem_en !== 1'b0 || mem_we !== 1'b0 || vid_valid !== 1'b0 || aux_rvalid !== 1'b0)
                $display("FAIL mid_after cyc=%0d: got en=%b we=%b vv=%b rv=%b required 0,0,0,0",
                         k, mem_en, mem_we, vid_valid, aux_rvalid);
            else pass_cnt++;
        end
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_phase_tick();
        test_video();
        test_camera();
        test_aux();
        test_contention();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
